// File: rtl/wishbone_line_arbiter.sv
// Round-robin arbiter sharing one line-wide classic Wishbone port between the I and D caches.
// Optional bus-wait timeout is compiled in with the WB_TIMEOUT_EN macro.
module wishbone_line_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int LINE_W         = 128,
    parameter int SEL_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    input  logic [SEL_W-1:0]  d_sel,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              err,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [LINE_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_sel,
    input  logic [LINE_W-1:0] wb_dat_i,
    input  logic              wb_ack,
    input  logic              wb_rty
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RETRY = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [LINE_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              timeout_hit;
    logic              i_pend, d_pend;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_pend || d_pend) begin
                    // I wins when alone, or on a tie when D was served last
                    if (i_pend && (!d_pend || last_q == GNT_D)) begin
                        grant_d = GNT_I;
                        we_d    = 1'b0;
                        adr_d   = i_address;
                        dat_d   = '0;
                        sel_d   = '1;
                    end else begin
                        grant_d = GNT_D;
                        we_d    = d_write;
                        adr_d   = d_address;
                        dat_d   = d_wdata;
                        sel_d   = d_sel;
                    end
                    rdata_d = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb_ack) begin
                    rdata_d = we_q ? '0 : wb_dat_i;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else if (wb_rty) begin
                    state_d = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (timeout_hit) begin
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RESP: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_I;
            last_q  <= GNT_D;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q counts completed BUS/RETRY cycles; the last allowed one is TIMEOUT_CYCLES-1
    assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
            end
            ST_BUS: begin
                cnt_d = cnt_q + 1'b1;
                err_d = timeout_hit && !wb_ack;
            end
            ST_RETRY: begin
                cnt_d = cnt_q + 1'b1;
                err_d = timeout_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = (state_q == ST_RESP) && err_q;
`else
    assign timeout_hit = 1'b0;
    // Without the timeout the limit has no role and err is constant low
    assign err = (TIMEOUT_CYCLES < 0);
`endif

    assign wb_cyc   = (state_q == ST_BUS);
    assign wb_stb   = wb_cyc;
    assign wb_we    = we_q;
    assign wb_adr   = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel   = sel_q;

    assign i_resp  = (state_q == ST_RESP) && (grant_q == GNT_I);
    assign d_resp  = (state_q == ST_RESP) && (grant_q == GNT_D);
    assign i_rdata = i_resp ? rdata_q : '0;
    assign d_rdata = d_resp ? rdata_q : '0;

endmodule

// File: tb/tb_wishbone_line_arbiter.sv
// Directed bench for wishbone_line_arbiter: arbitration order, write path, retry, async reset, timeout.
module tb_wishbone_line_arbiter;

    localparam int ADDR_W = 12;
    localparam int LINE_W = 128;
    localparam int SEL_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [SEL_W-1:0]  d_sel;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              err;
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_adr;
    logic [LINE_W-1:0] wb_dat_o;
    logic [SEL_W-1:0]  wb_sel;
    logic [LINE_W-1:0] wb_dat_i;
    logic              wb_ack;
    logic              wb_rty;

    int tests = 0;
    int fails = 0;

    localparam logic [LINE_W-1:0] DAT_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] DAT_11 = {16{8'h11}};
    localparam logic [LINE_W-1:0] DAT_22 = {16{8'h22}};
    localparam logic [LINE_W-1:0] DAT_33 = {16{8'h33}};
    localparam logic [LINE_W-1:0] DAT_77 = {16{8'h77}};
    localparam logic [LINE_W-1:0] DAT_99 = {16{8'h99}};
    localparam logic [LINE_W-1:0] DAT_44 = {16{8'h44}};
    localparam logic [LINE_W-1:0] WDATA  = 128'h1111_2222_DEAD_BEEF_3333_4444_5555_6666;

    wishbone_line_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .SEL_W(SEL_W), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_sel(d_sel), .d_resp(d_resp), .d_rdata(d_rdata), .err(err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack), .wb_rty(wb_rty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; d_sel = '0; wb_dat_i = '0; wb_ack = 0; wb_rty = 0;

        // Reset state
        step(); step();
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_we", wb_we, 0);
        check("rst_adr", wb_adr, 0);
        check("rst_dat_o", wb_dat_o, 0);
        check("rst_sel", wb_sel, 0);
        check("rst_i_resp", i_resp, 0);
        check("rst_d_resp", d_resp, 0);
        check("rst_err", err, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        rst_n = 1'b1;
        $display("[TB] reset state checked");

        // I read 0x123, ack on the fourth bus cycle
        i_read = 1; i_address = 12'h123;
        step();
        check("t1_cyc_c1", wb_cyc, 1);
        check("t1_stb_c1", wb_stb, 1);
        check("t1_adr", wb_adr, 12'h123);
        check("t1_sel", wb_sel, 16'hFFFF);
        check("t1_we", wb_we, 0);
        step(); step();
        check("t1_cyc_c3", wb_cyc, 1);
        step();
        check("t1_cyc_c4", wb_cyc, 1);
        check("t1_noresp_c4", i_resp, 0);
        wb_ack = 1; wb_dat_i = DAT_A5;
        step();
        wb_ack = 0; wb_dat_i = '0;
        check("t1_i_resp_c5", i_resp, 1);
        check("t1_i_rdata", i_rdata, DAT_A5);
        check("t1_d_resp", d_resp, 0);
        check("t1_cyc_c5", wb_cyc, 0);
        check("t1_err", err, 0);
        i_read = 0;
        step();
        check("t1_resp_pulse", i_resp, 0);
        wb_ack = 1;
        step();
        wb_ack = 0;
        check("idle_ack_i", i_resp, 0);
        check("idle_ack_d", d_resp, 0);
        check("idle_ack_cyc", wb_cyc, 0);
        $display("[TB] I read 0x123 done");

        // Simultaneous I/D after reset: I first, then D wins the next tie
        do_reset();
        i_read = 1; i_address = 12'h010; d_read = 1; d_address = 12'h020;
        step();
        check("t2_first_adr", wb_adr, 12'h010);
        check("t2_first_cyc", wb_cyc, 1);
        wb_ack = 1; wb_dat_i = DAT_11;
        step();
        wb_ack = 0;
        check("t2_i_resp", i_resp, 1);
        check("t2_i_rdata", i_rdata, DAT_11);
        check("t2_d_noresp", d_resp, 0);
        i_read = 0;
        step();
        check("t2_no_regrant_in_resp", wb_cyc, 0);
        i_read = 1; i_address = 12'h011;
        step();
        check("t2_tie_d_adr", wb_adr, 12'h020);
        check("t2_tie_d_cyc", wb_cyc, 1);
        wb_ack = 1; wb_dat_i = DAT_22;
        step();
        wb_ack = 0;
        check("t2_d_resp", d_resp, 1);
        check("t2_d_rdata", d_rdata, DAT_22);
        check("t2_i_noresp", i_resp, 0);
        d_read = 0;
        step();
        step();
        check("t2_then_i_adr", wb_adr, 12'h011);
        wb_ack = 1; wb_dat_i = DAT_33;
        step();
        wb_ack = 0;
        check("t2_i2_resp", i_resp, 1);
        check("t2_i2_rdata", i_rdata, DAT_33);
        i_read = 0;
        step();
        $display("[TB] simultaneous arbitration done");

        // D write (with d_read also high: write wins)
        d_write = 1; d_read = 1; d_address = 12'h0FF; d_sel = 16'h0030; d_wdata = WDATA;
        step();
        check("t3_we", wb_we, 1);
        check("t3_sel", wb_sel, 16'h0030);
        check("t3_adr", wb_adr, 12'h0FF);
        check("t3_dat_o", wb_dat_o, WDATA);
        d_wdata = DAT_77; d_address = 12'h0AA;
        step();
        check("t3_dat_hold", wb_dat_o, WDATA);
        check("t3_adr_hold", wb_adr, 12'h0FF);
        wb_ack = 1; wb_dat_i = DAT_99;
        step();
        wb_ack = 0;
        check("t3_d_resp", d_resp, 1);
        check("t3_d_rdata", d_rdata, 0);
        d_write = 0; d_read = 0;
        step();
        $display("[TB] D write done");

        // Retry, then ack+rty together
        i_read = 1; i_address = 12'h055;
        step();
        check("t4_cyc1", wb_cyc, 1);
        wb_rty = 1;
        step();
        wb_rty = 0;
        check("t4_retry_cyc", wb_cyc, 0);
        check("t4_retry_noresp", i_resp, 0);
        step();
        check("t4_reissue_cyc", wb_cyc, 1);
        check("t4_reissue_adr", wb_adr, 12'h055);
        check("t4_reissue_sel", wb_sel, 16'hFFFF);
        wb_ack = 1; wb_rty = 1; wb_dat_i = DAT_77;
        step();
        wb_ack = 0; wb_rty = 0;
        check("t4_i_resp", i_resp, 1);
        check("t4_i_rdata", i_rdata, DAT_77);
        check("t4_cyc_off", wb_cyc, 0);
        i_read = 0;
        step();
        $display("[TB] retry done");

        // Async reset mid-bus
        d_read = 1; d_address = 12'h321;
        step();
        check("t5_cyc", wb_cyc, 1);
        check("t5_adr", wb_adr, 12'h321);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_cyc", wb_cyc, 0);
        check("t5_async_stb", wb_stb, 0);
        check("t5_async_adr", wb_adr, 0);
        step();
        check("t5_no_d_resp", d_resp, 0);
        step();
        i_read = 1; i_address = 12'h0AB;
        rst_n = 1'b1;
        step();
        check("t5_i_pref_adr", wb_adr, 12'h0AB);
        wb_ack = 1; wb_dat_i = DAT_99;
        step();
        wb_ack = 0;
        check("t5_i_resp", i_resp, 1);
        i_read = 0;
        step();
        step();
        check("t5_d_adr", wb_adr, 12'h321);
        wb_ack = 1; wb_dat_i = DAT_44;
        step();
        wb_ack = 0;
        check("t5_d_resp", d_resp, 1);
        check("t5_d_rdata", d_rdata, DAT_44);
        d_read = 0;
        step();
        $display("[TB] async reset done");

        // No ack: timeout behaviour depends on build
        i_read = 1; i_address = 12'h0CC;
`ifdef WB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t6_cyc_wait", wb_cyc, 1);
        end
        step();
        check("t6_to_resp", i_resp, 1);
        check("t6_to_err", err, 1);
        check("t6_to_rdata", i_rdata, 0);
        check("t6_to_cyc", wb_cyc, 0);
        i_read = 0;
        step();
        check("t6_err_pulse", err, 0);
`else
        for (int k = 1; k <= 8; k++) step();
        check("t6_cyc_held", wb_cyc, 1);
        check("t6_no_resp", i_resp, 0);
        check("t6_err0", err, 0);
        wb_ack = 1; wb_dat_i = DAT_44;
        step();
        wb_ack = 0;
        check("t6_late_resp", i_resp, 1);
        check("t6_late_err", err, 0);
        check("t6_late_rdata", i_rdata, DAT_44);
        i_read = 0;
        step();
`endif
        $display("[TB] no-ack case done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
